ball_centroid_tracker: RTL

//  Consumes the VGA-timed RGB pixel stream (after Bayer-to-RGB, alongside the VGA controller) and marks pixels matching a

---
 rtl/ball_centroid_tracker.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ball_centroid_tracker.sv
// Ball colour-window detector: per-frame match count and X/Y coordinate sums,
// followed by a serial restoring divider that produces the ball centroid.
//
// state   | meaning
// IDLE    | accumulating pixels, waiting for frame end
// CHECK   | compare snapshot count against MIN_PIXELS
// DIV_X   | sumX / count, one quotient bit per cycle
// DIV_Y   | sumY / count, one quotient bit per cycle
// DONE    | publish results, pulse oVALID
module ball_centroid_tracker #(
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480,
    parameter int R_MIN      = 160,
    parameter int G_MAX      = 100,
    parameter int B_MAX      = 80,
    parameter int MIN_PIXELS = 64,
    parameter int SUM_W      = 28,
    parameter int CNT_W      = 19
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iDVAL,
    input  logic             iVS,
    input  logic [7:0]       iRed,
    input  logic [7:0]       iGreen,
    input  logic [7:0]       iBlue,
    output logic             oMASK,
    output logic [9:0]       oX,
    output logic [9:0]       oY,
    output logic [CNT_W-1:0] oCOUNT,
    output logic             oFOUND,
    output logic             oVALID,
    output logic             oDROP
);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int BW = $clog2(SUM_W);
    localparam logic [XW-1:0]    X_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0]    Y_END    = YW'(V_ACTIVE);
    localparam logic [BW-1:0]    BIT_LAST = BW'(SUM_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_PIXELS);
    localparam logic [7:0]       R_MIN_C  = 8'(R_MIN);
    localparam logic [7:0]       G_MAX_C  = 8'(G_MAX);
    localparam logic [7:0]       B_MAX_C  = 8'(B_MAX);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_DIV_X, S_DIV_Y, S_DONE} state_t;
    state_t state, state_next;

    logic             vs_q, dval_q;
    logic [XW-1:0]    x_pos;
    logic             x_full;
    logic [YW-1:0]    y_pos;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum_x, sum_y;

    logic [CNT_W-1:0] snap_cnt;
    logic [SUM_W-1:0] snap_sy;
    logic [SUM_W-1:0] div_num;
    logic [CNT_W-1:0] div_rem;
    logic [BW-1:0]    bit_cnt;
    logic [9:0]       quot_x;

    logic frame_end, line_end, colour_ok, in_range, match, found;
    logic [CNT_W:0]   rem_shift;
    logic             q_bit;
    logic [CNT_W-1:0] rem_next;
    logic [SUM_W-1:0] num_next;

    assign frame_end = vs_q & ~iVS;
    assign line_end  = dval_q & ~iDVAL;
    assign colour_ok = (iRed >= R_MIN_C) && (iGreen <= G_MAX_C) && (iBlue <= B_MAX_C);
    assign in_range  = !x_full && (y_pos < Y_END);
    assign match     = iDVAL & colour_ok & in_range;
    assign found     = (snap_cnt >= MIN_C);

    // Restoring divide step; the difference always fits CNT_W bits since rem < divisor.
    assign rem_shift = {div_rem, div_num[SUM_W-1]};
    assign q_bit     = (rem_shift >= {1'b0, snap_cnt});
    assign rem_next  = q_bit ? (rem_shift[CNT_W-1:0] - snap_cnt) : rem_shift[CNT_W-1:0];
    assign num_next  = {div_num[SUM_W-2:0], q_bit};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            vs_q   <= 1'b0;
            dval_q <= 1'b0;
            oMASK  <= 1'b0;
            x_pos  <= '0;
            x_full <= 1'b0;
            y_pos  <= '0;
            cnt    <= '0;
            sum_x  <= '0;
            sum_y  <= '0;
        end else begin
            vs_q   <= iVS;
            dval_q <= iDVAL;
            oMASK  <= match;
            if (frame_end) begin
                x_pos  <= '0;
                x_full <= 1'b0;
                y_pos  <= '0;
                cnt    <= '0;
                sum_x  <= '0;
                sum_y  <= '0;
            end else begin
                if (line_end) begin
                    x_pos  <= '0;
                    x_full <= 1'b0;
                    if (y_pos != Y_END) y_pos <= y_pos + 1'b1;
                end else if (iDVAL) begin
                    if (x_pos == X_LAST) x_full <= 1'b1;
                    else                 x_pos  <= x_pos + 1'b1;
                end
                if (match) begin
                    if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                    sum_x <= sum_x + SUM_W'(x_pos);
                    sum_y <= sum_y + SUM_W'(y_pos);
                end
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= S_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (frame_end) state_next = S_CHECK;
            S_CHECK: state_next = found ? S_DIV_X : S_DONE;
            S_DIV_X: if (bit_cnt == '0) state_next = S_DIV_Y;
            S_DIV_Y: if (bit_cnt == '0) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            snap_cnt <= '0;
            snap_sy  <= '0;
            div_num  <= '0;
            div_rem  <= '0;
            bit_cnt  <= '0;
            quot_x   <= '0;
            oX       <= '0;
            oY       <= '0;
            oCOUNT   <= '0;
            oFOUND   <= 1'b0;
            oVALID   <= 1'b0;
            oDROP    <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            // A frame end while busy loses its snapshot; the division in flight is untouched.
            oDROP  <= frame_end && (state != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (frame_end) begin
                        snap_cnt <= cnt;
                        div_num  <= sum_x;
                        snap_sy  <= sum_y;
                    end
                end
                S_CHECK: begin
                    div_rem <= '0;
                    bit_cnt <= BIT_LAST;
                end
                S_DIV_X: begin
                    div_rem <= rem_next;
                    div_num <= num_next;
                    bit_cnt <= bit_cnt - 1'b1;
                    if (bit_cnt == '0) begin
                        quot_x  <= num_next[9:0];
                        div_num <= snap_sy;
                        div_rem <= '0;
                        bit_cnt <= BIT_LAST;
                    end
                end
                S_DIV_Y: begin
                    div_rem <= rem_next;
                    div_num <= num_next;
                    bit_cnt <= bit_cnt - 1'b1;
                end
                S_DONE: begin
                    oVALID <= 1'b1;
                    oCOUNT <= snap_cnt;
                    oFOUND <= found;
                    if (found) begin
                        oX <= quot_x;
                        oY <= div_num[9:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
